// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: WIDTH-bit operands in, full 2*WIDTH-bit product out.
// Signed operations run on magnitudes and the sign is applied to the final sum.
module iter_multiplier #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 op_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [PW-1:0]     acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              neg_r;
    logic [PW-1:0]     product_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic              signed_mode_s;
    logic [WIDTH-1:0]  mag_a_s;
    logic [WIDTH-1:0]  mag_b_s;
    logic [PW-1:0]     partial_s;
    logic [PW-1:0]     acc_next_s;
    logic [PW-1:0]     result_s;

    // Most negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             is_signed);
        if (is_signed && value[WIDTH-1]) begin
            magnitude = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = value;
        end
    endfunction

    // Operand conditioning, per-step partial product and sign-corrected result
    always_comb begin
        signed_mode_s = op_signed & SIGNED_EN;
        mag_a_s       = magnitude(op_a, signed_mode_s);
        mag_b_s       = magnitude(op_b, signed_mode_s);
        partial_s     = {PW{1'b0}};
        if (mplier_r[0]) begin
            partial_s = mcand_r << cnt_r;
        end else begin
            partial_s = {PW{1'b0}};
        end
        acc_next_s = acc_r + partial_s;
        if (neg_r) begin
            result_s = ~acc_next_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            result_s = acc_next_s;
        end
    end

    // Control FSM and datapath registers, all outputs registered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            mcand_r     <= {PW{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            acc_r       <= {PW{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            neg_r       <= 1'b0;
            product_r   <= {PW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand_r    <= {{WIDTH{1'b0}}, mag_a_s};
                        mplier_r   <= mag_b_s;
                        neg_r      <= signed_mode_s & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_r      <= {PW{1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        product_r   <= result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign product   = product_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed bench for iter_multiplier: an 8-bit signed-capable instance and a
// 16-bit instance with signed mode disabled, sharing one clock.
module tb_iter_multiplier;

    logic        clk_s = 1'b0;
    logic        rst_s;

    logic        in_valid_s, in_ready_s, op_signed_s, out_valid_s, out_ready_s, busy_s;
    logic [7:0]  op_a_s, op_b_s;
    logic [15:0] product_s;

    logic        in_valid16_s, in_ready16_s, op_signed16_s, out_valid16_s, out_ready16_s, busy16_s;
    logic [15:0] op_a16_s, op_b16_s;
    logic [31:0] product16_s;

    int n_checks   = 0;
    int n_failures = 0;

    iter_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .wb_clk_i(clk_s), .wb_rst_i(rst_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .op_a(op_a_s), .op_b(op_b_s), .op_signed(op_signed_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .product(product_s), .busy(busy_s)
    );

    iter_multiplier #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
        .wb_clk_i(clk_s), .wb_rst_i(rst_s),
        .in_valid(in_valid16_s), .in_ready(in_ready16_s),
        .op_a(op_a16_s), .op_b(op_b16_s), .op_signed(op_signed16_s),
        .out_valid(out_valid16_s), .out_ready(out_ready16_s),
        .product(product16_s), .busy(busy16_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Issue one op on the 8-bit instance with out_ready high and check latency, result, return to idle
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                           input logic [15:0] exp, input string tag);
        int cyc;
        check_value({tag, "/ready"}, 64'(in_ready_s), 64'd1);
        in_valid_s  = 1'b1;
        op_a_s      = a;
        op_b_s      = b;
        op_signed_s = sgn;
        tick();
        in_valid_s = 1'b0;
        op_a_s     = 8'h00;
        op_b_s     = 8'h00;
        check_value({tag, "/calc_busy"}, 64'({busy_s, in_ready_s, out_valid_s}), 64'b100);
        cyc = 0;
        while (!out_valid_s && cyc < 40) begin
            tick();
            cyc++;
        end
        check_value({tag, "/latency"}, 64'(cyc), 64'd8);
        check_value({tag, "/product"}, 64'(product_s), 64'(exp));
        tick();
        check_value({tag, "/idle"}, 64'({in_ready_s, out_valid_s, busy_s}), 64'b100);
    endtask

    initial begin
        int cyc;
        rst_s         = 1'b1;
        in_valid_s    = 1'b0; op_a_s = 8'h00; op_b_s = 8'h00; op_signed_s = 1'b0;
        out_ready_s   = 1'b1;
        in_valid16_s  = 1'b0; op_a16_s = 16'h0000; op_b16_s = 16'h0000; op_signed16_s = 1'b0;
        out_ready16_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        check_value("reset8", 64'({in_ready_s, out_valid_s, busy_s, product_s}), {45'd0, 3'b100, 16'h0000});
        check_value("reset16", 64'({in_ready16_s, out_valid16_s, busy16_s, product16_s}), {29'd0, 3'b100, 32'h0});

        run_op8(8'd13, 8'd11, 1'b0, 16'h008F, "u13x11");
        run_op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
        run_op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1");
        run_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uFFxFF");
        run_op8(8'h80, 8'h80, 1'b1, 16'h4000, "s80x80");
        run_op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s80x7F");
        run_op8(8'h05, 8'hFD, 1'b1, 16'hFFF1, "s5xm3");

        // Backpressure: result held under out_ready=0 while inputs wiggle
        out_ready_s = 1'b0;
        in_valid_s  = 1'b1; op_a_s = 8'd7; op_b_s = 8'd9; op_signed_s = 1'b0;
        tick();
        in_valid_s = 1'b0;
        cyc = 0;
        while (!out_valid_s && cyc < 40) begin
            tick();
            cyc++;
        end
        check_value("bp/latency", 64'(cyc), 64'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid_s = ~in_valid_s;
            op_a_s     = op_a_s + 8'd17;
            tick();
            check_value("bp/hold", 64'({product_s, out_valid_s, in_ready_s}), {46'd0, 16'h003F, 2'b10});
        end
        in_valid_s  = 1'b0;
        out_ready_s = 1'b1;
        tick();
        check_value("bp/release", 64'({in_ready_s, out_valid_s, busy_s}), 64'b100);

        // Reset mid-calculation at counter=4
        in_valid_s = 1'b1; op_a_s = 8'h12; op_b_s = 8'h34; op_signed_s = 1'b0;
        tick();
        in_valid_s = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_value("rst/in_calc", 64'({busy_s, out_valid_s}), 64'b10);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        check_value("rst/values", 64'({in_ready_s, out_valid_s, busy_s, product_s}), {45'd0, 3'b100, 16'h0000});
        tick();
        check_value("rst/stays_idle", 64'({in_ready_s, out_valid_s, busy_s}), 64'b100);
        run_op8(8'h00, 8'hAB, 1'b1, 16'h0000, "s0xAB");

        // 16-bit instance ignores op_signed
        in_valid16_s = 1'b1; op_a16_s = 16'hFFFF; op_b16_s = 16'hFFFF; op_signed16_s = 1'b1;
        tick();
        in_valid16_s = 1'b0;
        cyc = 0;
        while (!out_valid16_s && cyc < 60) begin
            tick();
            cyc++;
        end
        check_value("w16/latency", 64'(cyc), 64'd16);
        check_value("w16/product", 64'(product16_s), 64'h0000_0000_FFFE_0001);
        tick();
        check_value("w16/idle", 64'({in_ready16_s, out_valid16_s, busy16_s}), 64'b100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
